// File: rtl/kbd_pkg.sv
// kbd_pkg
//   Shared definitions for the keypad encoding path:
//     KEY_CODE_W  width of a key code {row[1:0], col[1:0]}
//     kbd_state_t encoder FSM states (IDLE, CAPT, SCAN)
//     make_code   packs a row index and a column index into a key code
package kbd_pkg;

  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    SCAN = 2'd2
  } kbd_state_t;

  function automatic logic [KEY_CODE_W-1:0] make_code(input logic [1:0] row,
                                                      input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// kbd_sync_fifo
//   Generic synchronous first-word-fall-through FIFO.
//   Ports:
//     clk, rst  clock and synchronous active-high reset
//     push      write wr_data; accepted when not full, or when full and
//               a pop happens in the same cycle
//     wr_data   entry to write
//     pop       remove the head entry; ignored when empty
//     rd_data   head entry, shown combinationally; 0 while empty
//     empty     no entries stored
//     full      DEPTH entries stored
//     count     number of stored entries
import kbd_pkg::*;

module kbd_sync_fifo #(
  parameter  int WIDTH = KEY_CODE_W,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_count;
  logic             w_doPop;
  logic             w_doPush;

  // Pointers carry one extra wrap bit so the difference distinguishes
  // full from empty without a separate flag.
  assign w_count = r_wptr - r_rptr;
  assign count   = w_count;
  assign empty   = (w_count == '0);
  assign full    = (w_count == (AW+1)'(DEPTH));

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  // Forcing 0 while empty keeps rd_data defined without resetting storage.
  assign rd_data = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + 1'b1;
      if (w_doPop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/key_fifo_encoder.sv
// key_fifo_encoder
//   Turns keypad row-scanner results into 4-bit key codes and queues them
//   in a FWFT FIFO for the CPU-side wrapper.
//   Ports:
//     clk, rst  clock and synchronous active-high reset
//     row_rdy   one-cycle pulse: a row result is available
//     hi        row index of that result
//     col_out   active-low newly-pressed column mask
//     rd_en     pop the head code (ignored when empty)
//     clr_ovf   clear the sticky overflow flag
//     rd_data   head code {row, col}, valid while !empty
//     empty     FIFO holds no codes
//     full      FIFO holds DEPTH codes
//     count     number of stored codes
//     ovf       sticky: a code or a row event was lost
//     irq       level interrupt, high while codes are pending
import kbd_pkg::*;

module key_fifo_encoder #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  row_rdy,
  input  logic [1:0]            hi,
  input  logic [3:0]            col_out,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [KEY_CODE_W-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  ovf,
  output logic                  irq
);

  kbd_state_t            r_state;
  logic [3:0]            r_mask;
  logic [1:0]            r_row;
  logic [1:0]            r_col;
  logic                  r_ovf;
  logic                  w_pushReq;
  logic                  w_pushDrop;
  logic                  w_rowDrop;
  logic [KEY_CODE_W-1:0] w_code;

  // One push opportunity per SCAN cycle, for the column currently indexed.
  assign w_pushReq = (r_state == SCAN) && r_mask[r_col];
  assign w_code    = make_code(r_row, r_col);

  // A full FIFO only loses the code when no pop makes room this cycle.
  assign w_pushDrop = w_pushReq && full && !rd_en;
  assign w_rowDrop  = row_rdy && (r_state != IDLE);

  // IDLE waits for a row result, CAPT samples the settled scanner outputs,
  // SCAN walks columns 0..3 (always four cycles, even for an empty mask).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (row_rdy) r_state <= CAPT;
        end
        CAPT: begin
          r_mask  <= ~col_out;
          r_row   <= hi;
          r_col   <= '0;
          r_state <= SCAN;
        end
        SCAN: begin
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky overflow; a new loss event takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_pushDrop || w_rowDrop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
  assign irq = !empty;

  kbd_sync_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_pushReq),
    .wr_data (w_code),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_key_fifo_encoder.sv
// tb_key_fifo_encoder
//   Directed scoreboard bench for key_fifo_encoder. Stimulus pushes the
//   hand-computed key codes into a queue; a monitor drains the FIFO when
//   asked and compares every popped code against the queue head.
module tb_key_fifo_encoder;

  logic       clk;
  logic       rst;
  logic       row_rdy;
  logic [1:0] hi;
  logic [3:0] col_out;
  logic       rd_en;
  logic       clr_ovf;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       ovf;
  logic       irq;

  int compared;
  int mismatched;

  logic [3:0] expQ[$];
  logic       drainEn;
  logic       popOnce;
  logic       monDone;

  key_fifo_encoder #(.DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .row_rdy (row_rdy),
    .hi      (hi),
    .col_out (col_out),
    .rd_en   (rd_en),
    .clr_ovf (clr_ovf),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic comparison used by both the stimulus checks and the monitor.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one row result at the current negedge and let the FSM finish.
  task automatic applyStimulus(input logic [1:0] row, input logic [3:0] cols);
    row_rdy = 1'b1;
    hi      = row;
    col_out = cols;
    tick(1);
    row_rdy = 1'b0;
    tick(7);
    col_out = 4'b1111;
  endtask

  task automatic expectRow(input logic [1:0] row, input logic [3:0] cols);
    for (int c = 0; c < 4; c++) begin
      if (!cols[c]) expQ.push_back({row, 2'(c)});
    end
  endtask

  // Drain through the monitor until the DUT reports empty, bounded.
  task automatic drainAll(input string name);
    int n;
    n = 0;
    drainEn = 1'b1;
    while (!empty && n < 40) begin
      tick(1);
      n++;
    end
    tick(1);
    drainEn = 1'b0;
    tick(1);
    checkOutput({name, "_drained"}, 8'(empty), 8'd1);
  endtask

  // Monitor: pops and compares whenever a drain is requested and the DUT
  // presents a valid head code.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      rd_en = 1'b0;
      if (!monDone && !rst && (drainEn || popOnce) && !empty) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_code", 8'(rd_data), 8'hFF);
        end else begin
          checkOutput("pop_code", 8'(rd_data), 8'(expQ.pop_front()));
        end
        rd_en = 1'b1;
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    drainEn    = 1'b0;
    popOnce    = 1'b0;
    monDone    = 1'b0;
    rst        = 1'b1;
    row_rdy    = 1'b0;
    hi         = 2'd0;
    col_out    = 4'b1111;
    clr_ovf    = 1'b0;

    // Reset and idle
    tick(3);
    rst = 1'b0;
    tick(10);
    checkOutput("rst_empty", 8'(empty), 8'd1);
    checkOutput("rst_full", 8'(full), 8'd0);
    checkOutput("rst_count", 8'(count), 8'd0);
    checkOutput("rst_irq", 8'(irq), 8'd0);
    checkOutput("rst_ovf", 8'(ovf), 8'd0);
    checkOutput("rst_rd_data", 8'(rd_data), 8'd0);

    // Row 2, columns 1 and 3 pressed: codes 9 then B, with latency checks
    expQ.push_back(4'h9);
    expQ.push_back(4'hB);
    row_rdy = 1'b1;
    hi      = 2'd2;
    col_out = 4'b0101;
    tick(1);
    row_rdy = 1'b0;
    tick(2);
    checkOutput("lat_count_c0", 8'(count), 8'd0);
    tick(1);
    checkOutput("lat_count_c1", 8'(count), 8'd1);
    checkOutput("lat_head", 8'(rd_data), 8'h9);
    checkOutput("lat_empty", 8'(empty), 8'd0);
    tick(4);
    col_out = 4'b1111;
    checkOutput("two_count", 8'(count), 8'd2);
    checkOutput("two_irq", 8'(irq), 8'd1);
    drainAll("two");
    checkOutput("two_irq_after", 8'(irq), 8'd0);

    // No key pressed: nothing pushed
    applyStimulus(2'd1, 4'b1111);
    checkOutput("none_count", 8'(count), 8'd0);
    checkOutput("none_empty", 8'(empty), 8'd1);
    checkOutput("none_ovf", 8'(ovf), 8'd0);

    // Fill to full, then overflow with a third event
    expectRow(2'd0, 4'b0000);
    applyStimulus(2'd0, 4'b0000);
    expectRow(2'd1, 4'b0000);
    applyStimulus(2'd1, 4'b0000);
    checkOutput("fill_full", 8'(full), 8'd1);
    checkOutput("fill_count", 8'(count), 8'd8);
    checkOutput("fill_ovf", 8'(ovf), 8'd0);
    applyStimulus(2'd3, 4'b0000);
    checkOutput("ovf_set", 8'(ovf), 8'd1);
    checkOutput("ovf_count", 8'(count), 8'd8);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", 8'(ovf), 8'd0);
    drainAll("fill");

    // Refill, then push into a full FIFO while popping in the same cycle
    expectRow(2'd2, 4'b0000);
    applyStimulus(2'd2, 4'b0000);
    expectRow(2'd3, 4'b0000);
    applyStimulus(2'd3, 4'b0000);
    checkOutput("refill_full", 8'(full), 8'd1);
    expQ.push_back(4'h4);
    row_rdy = 1'b1;
    hi      = 2'd1;
    col_out = 4'b1110;
    tick(1);
    row_rdy = 1'b0;
    @(posedge clk);
    #1 popOnce = 1'b1;
    @(posedge clk);
    #1 popOnce = 1'b0;
    tick(6);
    col_out = 4'b1111;
    checkOutput("simul_count", 8'(count), 8'd8);
    checkOutput("simul_ovf", 8'(ovf), 8'd0);
    checkOutput("simul_head", 8'(rd_data), 8'h9);
    drainAll("simul");

    // Row event dropped during SCAN, then reset mid-SCAN
    row_rdy = 1'b1;
    hi      = 2'd2;
    col_out = 4'b0110;
    tick(1);
    row_rdy = 1'b0;
    tick(2);
    row_rdy = 1'b1;
    hi      = 2'd1;
    tick(1);
    row_rdy = 1'b0;
    checkOutput("drop_ovf", 8'(ovf), 8'd1);
    checkOutput("drop_count", 8'(count), 8'd1);
    checkOutput("drop_head", 8'(rd_data), 8'h8);
    rst = 1'b1;
    tick(1);
    rst     = 1'b0;
    col_out = 4'b1111;
    tick(6);
    checkOutput("mid_rst_count", 8'(count), 8'd0);
    checkOutput("mid_rst_empty", 8'(empty), 8'd1);
    checkOutput("mid_rst_ovf", 8'(ovf), 8'd0);
    checkOutput("mid_rst_irq", 8'(irq), 8'd0);
    checkOutput("mid_rst_rd_data", 8'(rd_data), 8'd0);

    // FSM resumes normally after reset
    expectRow(2'd0, 4'b1101);
    applyStimulus(2'd0, 4'b1101);
    checkOutput("resume_count", 8'(count), 8'd1);
    drainAll("resume");

    monDone = 1'b1;
    tick(2);
    checkOutput("scoreboard_left", 8'(expQ.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
